// File: rtl/reg_scoreboard_pkg.sv
// Shared defaults and producer latency classes for the ID-stage register scoreboard.
package reg_scoreboard_pkg;

  localparam int NREG_DEF    = 16;
  localparam int RADDR_W_DEF = 4;
  localparam int NSRC_DEF    = 2;
  localparam int MAX_LAT_DEF = 3;
  localparam int CNT_W_DEF   = 2;
  localparam int PERF_W_DEF  = 16;

  typedef enum logic [1:0] {
    LAT_ALU   = 2'd0,
    LAT_LOAD  = 2'd1,
    LAT_MULTI = 2'd2
  } lat_class_e;

endpackage

// File: rtl/reg_scoreboard_if.sv
// Decode-stage issue/source bundle between the ID stage (master) and the scoreboard (slave).
interface reg_scoreboard_if
  import reg_scoreboard_pkg::*;
#(
  parameter int NREG    = NREG_DEF,
  parameter int RADDR_W = RADDR_W_DEF,
  parameter int NSRC    = NSRC_DEF,
  parameter int CNT_W   = CNT_W_DEF,
  parameter int PERF_W  = PERF_W_DEF
) ();

  logic                    issue_valid;
  logic                    issue_we;
  logic [RADDR_W-1:0]      issue_dst;
  logic [CNT_W-1:0]        issue_lat;
  logic                    flush;
  logic [NSRC-1:0]         src_valid;
  logic [NSRC*RADDR_W-1:0] src_addr;
  logic                    stall;
  logic [NSRC-1:0]         src_hazard;
  logic [NREG-1:0]         busy_vec;
  logic [PERF_W-1:0]       stall_cycles;

  modport master (
    output issue_valid, issue_we, issue_dst, issue_lat, flush, src_valid, src_addr,
    input  stall, src_hazard, busy_vec, stall_cycles
  );

  modport slave (
    input  issue_valid, issue_we, issue_dst, issue_lat, flush, src_valid, src_addr,
    output stall, src_hazard, busy_vec, stall_cycles
  );

endinterface

// File: rtl/reg_scoreboard_sb_counter.sv
// One register's pending-result down-counter; a load overrides the decrement.
module sb_counter #(
  parameter int CNT_W = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             busy
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign busy = (cnt_q != '0);

endmodule

// File: rtl/reg_scoreboard.sv
// Per-register pending-write scoreboard: combinational RAW stall for decode plus a stall counter.
module reg_scoreboard
  import reg_scoreboard_pkg::*;
#(
  parameter int NREG    = NREG_DEF,
  parameter int RADDR_W = RADDR_W_DEF,
  parameter int NSRC    = NSRC_DEF,
  parameter int MAX_LAT = MAX_LAT_DEF,
  parameter int CNT_W   = CNT_W_DEF,
  parameter int PERF_W  = PERF_W_DEF
) (
  input logic             clk,
  input logic             rst_n,
  reg_scoreboard_if.slave sb
);

  logic [NREG-1:0]   busy;
  logic [NSRC-1:0]   hazard;
  logic              stall;
  logic              accept;
  logic [CNT_W-1:0]  lat_clamped;
  logic [PERF_W-1:0] stall_cycles_q;
  logic [PERF_W-1:0] stall_cycles_d;

  // Register 0 never holds a pending result.
  assign busy[0] = 1'b0;

  always_comb begin
    hazard = '0;
    for (int i = 0; i < NSRC; i++) begin
      hazard[i] = sb.src_valid[i]
                  && (sb.src_addr[i*RADDR_W +: RADDR_W] != '0)
                  && busy[sb.src_addr[i*RADDR_W +: RADDR_W]];
    end
  end

  assign stall  = |hazard;
  assign accept = sb.issue_valid && sb.issue_we && !stall && !sb.flush
                  && (sb.issue_dst != '0);

  always_comb begin
    lat_clamped = sb.issue_lat;
    if ({1'b0, sb.issue_lat} > (CNT_W+1)'(MAX_LAT)) begin
      lat_clamped = CNT_W'(MAX_LAT);
    end
  end

  for (genvar r = 1; r < NREG; r++) begin : g_cnt
    sb_counter #(
      .CNT_W (CNT_W)
    ) u_cnt (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (accept && (sb.issue_dst == RADDR_W'(r))),
      .load_val (lat_clamped),
      .busy     (busy[r])
    );
  end

  always_comb begin
    stall_cycles_d = stall_cycles_q;
    if (stall && (stall_cycles_q != '1)) begin
      stall_cycles_d = stall_cycles_q + PERF_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_cycles_q <= '0;
    end else begin
      stall_cycles_q <= stall_cycles_d;
    end
  end

  assign sb.stall        = stall;
  assign sb.src_hazard   = hazard;
  assign sb.busy_vec     = busy;
  assign sb.stall_cycles = stall_cycles_q;

endmodule
